// File: rtl/bubble_pkg.sv
// bubble_pkg: shared state encoding and fixed-point helpers for the bubble mover.
package bubble_pkg;
  typedef enum logic [1:0] {IDLE, MOVE, FREEZE, SPLIT} state_e;
  typedef logic signed [31:0] fx_t;
  function automatic fx_t to_fx(input logic [10:0] px, input int frac);
    return fx_t'({21'd0, px}) <<< frac;
  endfunction
  function automatic logic [10:0] from_fx(input fx_t v, input int frac);
    fx_t s;
    s = v >>> frac;
    return s[10:0];
  endfunction
endpackage

// File: rtl/bubble_bounce_calc.sv
// bubble_bounce_calc: one frame of motion with wall, floor and ceiling handling.
module bubble_bounce_calc
  import bubble_pkg::*;
#(
  parameter int FRAC_BITS     = 6,
  parameter int LEVEL_W       = 2,
  parameter int SIZE_BASE     = 8,
  parameter int SCREEN_W      = 640,
  parameter int FLOOR_Y       = 440,
  parameter int X_SPEED       = 64,
  parameter int GRAVITY       = 4,
  parameter int BOUNCE_V_BASE = 192,
  parameter int BOUNCE_V_STEP = 64,
  parameter int MAX_FALL      = 512
) (
  input  fx_t                x_i,
  input  fx_t                y_i,
  input  fx_t                xs_i,
  input  fx_t                ys_i,
  input  logic [LEVEL_W-1:0] level_i,
  output fx_t                x_o,
  output fx_t                y_o,
  output fx_t                xs_o,
  output fx_t                ys_o
);
  localparam fx_t XS = fx_t'(X_SPEED);
  localparam fx_t MF = fx_t'(MAX_FALL);
  fx_t size_fx, x_max, y_floor, bounce, nx, ny, ys_g;
  logic floor_hit;
  always_comb begin
    size_fx   = fx_t'(SIZE_BASE) <<< (32'(level_i) + 32'(FRAC_BITS));
    x_max     = (fx_t'(SCREEN_W) <<< FRAC_BITS) - size_fx;
    y_floor   = (fx_t'(FLOOR_Y) <<< FRAC_BITS) - size_fx;
    bounce    = fx_t'(BOUNCE_V_BASE) + fx_t'(BOUNCE_V_STEP) * fx_t'(level_i);
    nx        = x_i + xs_i;
    ny        = y_i + ys_i;
    ys_g      = (ys_i + fx_t'(GRAVITY) > MF) ? MF : ys_i + fx_t'(GRAVITY);
    floor_hit = (ny >= y_floor) && (ys_i > 0);
    x_o       = (nx < 0) ? '0 : (nx > x_max) ? x_max : nx;
    xs_o      = (nx < 0) ? XS : (nx > x_max) ? -XS : xs_i;
    y_o       = floor_hit ? y_floor : (ny < 0) ? '0 : ny;
    ys_o      = floor_hit ? -bounce : (ny < 0) ? '0 : ys_g;
  end
endmodule

// File: rtl/bubble_move.sv
// bubble_move: one bubble's launch/move/freeze/split lifecycle with fixed-point motion.
module bubble_move
  import bubble_pkg::*;
#(
  parameter int FRAC_BITS     = 6,
  parameter int LEVEL_W       = 2,
  parameter int SIZE_BASE     = 8,
  parameter int SCREEN_W      = 640,
  parameter int FLOOR_Y       = 440,
  parameter int X_SPEED       = 64,
  parameter int GRAVITY       = 4,
  parameter int BOUNCE_V_BASE = 192,
  parameter int BOUNCE_V_STEP = 64,
  parameter int MAX_FALL      = 512,
  parameter int FREEZE_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               launch,
  input  logic [10:0]        init_x,
  input  logic [10:0]        init_y,
  input  logic               init_dir,
  input  logic [LEVEL_W-1:0] init_level,
  input  logic               hit,
  input  logic               pause,
  output logic [10:0]        topLeftX,
  output logic [10:0]        topLeftY,
  output logic [10:0]        size,
  output logic [LEVEL_W-1:0] level,
  output logic               active,
  output logic               split_req,
  output logic               popped
);
  localparam int CW = $clog2(FREEZE_FRAMES + 1);
  localparam fx_t XS = fx_t'(X_SPEED);
  state_e state_q;
  fx_t x_q, y_q, xs_q, ys_q, x_d, y_d, xs_d, ys_d;
  logic [LEVEL_W-1:0] level_q;
  logic [CW-1:0] cnt_q;
  logic active_q, split_q, pop_q;
  logic step;
  assign step = startOfFrame && !pause;
  bubble_bounce_calc #(
    .FRAC_BITS(FRAC_BITS), .LEVEL_W(LEVEL_W), .SIZE_BASE(SIZE_BASE), .SCREEN_W(SCREEN_W),
    .FLOOR_Y(FLOOR_Y), .X_SPEED(X_SPEED), .GRAVITY(GRAVITY), .BOUNCE_V_BASE(BOUNCE_V_BASE),
    .BOUNCE_V_STEP(BOUNCE_V_STEP), .MAX_FALL(MAX_FALL)
  ) u_calc (
    .x_i(x_q), .y_i(y_q), .xs_i(xs_q), .ys_i(ys_q), .level_i(level_q),
    .x_o(x_d), .y_o(y_d), .xs_o(xs_d), .ys_o(ys_d)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      xs_q     <= '0;
      ys_q     <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      split_q  <= 1'b0;
      pop_q    <= 1'b0;
    end else begin
      split_q <= 1'b0;
      pop_q   <= 1'b0;
      case (state_q)
        IDLE: if (launch) begin
          x_q      <= to_fx(init_x, FRAC_BITS);
          y_q      <= to_fx(init_y, FRAC_BITS);
          xs_q     <= init_dir ? XS : -XS;
          ys_q     <= '0;
          level_q  <= init_level;
          active_q <= 1'b1;
          state_q  <= MOVE;
        end
        MOVE: if (hit) begin
          cnt_q   <= CW'(FREEZE_FRAMES);
          state_q <= FREEZE;
        end else if (step) begin
          x_q  <= x_d;
          y_q  <= y_d;
          xs_q <= xs_d;
          ys_q <= ys_d;
        end
        // pulses are set on entry so they are high exactly while in SPLIT
        FREEZE: if (cnt_q == '0) begin
          split_q  <= level_q != '0;
          pop_q    <= level_q == '0;
          active_q <= 1'b0;
          state_q  <= SPLIT;
        end else if (step) begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign topLeftX  = from_fx(x_q, FRAC_BITS);
  assign topLeftY  = from_fx(y_q, FRAC_BITS);
  assign size      = 11'(SIZE_BASE << level_q);
  assign level     = level_q;
  assign active    = active_q;
  assign split_req = split_q;
  assign popped    = pop_q;
endmodule

// File: tb/tb_bubble_move.sv
// tb_bubble_move: scoreboard bench; stimulus queues expectations, monitors pop and compare.
module tb_bubble_move;
  logic clk = 1'b0;
  logic reset = 1'b1, startOfFrame = 1'b0, launch = 1'b0, init_dir = 1'b0, hit = 1'b0, pause = 1'b0;
  logic probe = 1'b0;
  logic [10:0] init_x = '0, init_y = '0;
  logic [1:0] init_level = '0;
  logic [10:0] o_x, o_y, o_size;
  logic [1:0] o_level;
  logic o_active, o_split, o_pop;
  int checks = 0, failures = 0;
  typedef struct packed {logic [10:0] x, y, sz; logic [1:0] lvl; logic act;} exp_t;
  typedef struct packed {logic sp; logic [1:0] lvl;} pulse_t;
  exp_t eq[$];
  string nq[$];
  pulse_t pq[$];
  string pnq[$];

  bubble_move dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .launch(launch),
    .init_x(init_x), .init_y(init_y), .init_dir(init_dir), .init_level(init_level),
    .hit(hit), .pause(pause), .topLeftX(o_x), .topLeftY(o_y), .size(o_size),
    .level(o_level), .active(o_active), .split_req(o_split), .popped(o_pop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", n, got, exp);
    end
  endtask

  function automatic void push(input string n, input int x, input int y, input int lvl, input int act);
    exp_t e;
    e.x = 11'(x);
    e.y = 11'(y);
    e.lvl = 2'(lvl);
    e.act = act[0];
    e.sz = 11'(8 << lvl);
    eq.push_back(e);
    nq.push_back(n);
  endfunction

  function automatic void expect_pulse(input string n, input bit sp, input int lvl);
    pulse_t p;
    p.sp = sp;
    p.lvl = 2'(lvl);
    pq.push_back(p);
    pnq.push_back(n);
  endfunction

  // state monitor: one expectation per frame or probe cycle
  initial forever begin
    @(posedge clk);
    if (startOfFrame || probe) begin
      @(negedge clk);
      if (eq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow got=empty expected=entry");
      end else begin
        exp_t e;
        string n;
        e = eq.pop_front();
        n = nq.pop_front();
        chk({n, ".x"}, 32'(o_x), 32'(e.x));
        chk({n, ".y"}, 32'(o_y), 32'(e.y));
        chk({n, ".size"}, 32'(o_size), 32'(e.sz));
        chk({n, ".level"}, 32'(o_level), 32'(e.lvl));
        chk({n, ".active"}, 32'(o_active), 32'(e.act));
      end
    end
  end

  // pulse monitor: every pulse must match a queued expectation
  initial forever begin
    @(negedge clk);
    if (o_split || o_pop) begin
      if (pq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse got=split%0d/pop%0d expected=none", o_split, o_pop);
      end else begin
        pulse_t p;
        string n;
        p = pq.pop_front();
        n = pnq.pop_front();
        chk({n, ".split_req"}, 32'(o_split), 32'(p.sp));
        chk({n, ".popped"}, 32'(o_pop), 32'(!p.sp));
        chk({n, ".level"}, 32'(o_level), 32'(p.lvl));
        chk({n, ".active"}, 32'(o_active), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap(input string n, input int x, input int y, input int lvl, input int act);
    push(n, x, y, lvl, act);
    @(negedge clk) probe = 1'b1;
    @(negedge clk) probe = 1'b0;
  endtask

  task automatic frame(input string n, input int x, input int y, input int lvl, input int act, input bit p = 1'b0);
    push(n, x, y, lvl, act);
    @(negedge clk) begin startOfFrame = 1'b1; pause = p; end
    @(negedge clk) begin startOfFrame = 1'b0; pause = 1'b0; end
  endtask

  task automatic do_launch(input int x, input int y, input bit dir, input int lvl, input bit h = 1'b0);
    @(negedge clk) begin
      init_x = 11'(x); init_y = 11'(y); init_dir = dir; init_level = 2'(lvl);
      launch = 1'b1; hit = h;
    end
    @(negedge clk) begin launch = 1'b0; hit = 1'b0; end
  endtask

  task automatic do_hit(input string n, input bit sof, input int x, input int y, input int lvl);
    if (sof) push(n, x, y, lvl, 1);
    @(negedge clk) begin hit = 1'b1; startOfFrame = sof; end
    @(negedge clk) begin hit = 1'b0; startOfFrame = 1'b0; end
  endtask

  task automatic do_reset;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    reset = 1'b0;
    snap("reset", 0, 0, 0, 0);
    // basic motion and accumulating gravity
    do_launch(100, 50, 1, 0);
    snap("t1_launch", 100, 50, 0, 1);
    for (int i = 1; i <= 7; i++) frame("t1_frame", 100 + i, (i == 7) ? 51 : 50, 0, 1);
    // right wall
    do_reset;
    do_launch(630, 100, 1, 0);
    frame("t2_f1", 631, 100, 0, 1);
    frame("t2_f2", 632, 100, 0, 1);
    frame("t2_clamp", 632, 100, 0, 1);
    frame("t2_left1", 631, 100, 0, 1);
    frame("t2_left2", 630, 100, 0, 1);
    // left wall at level 2
    do_reset;
    do_launch(1, 100, 0, 2);
    frame("t7_f1", 0, 100, 2, 1);
    frame("t7_clamp", 0, 100, 2, 1);
    frame("t7_right", 1, 100, 2, 1);
    // floor bounce at level 1
    do_reset;
    do_launch(200, 431, 0, 1);
    frame("t3_f1", 199, 431, 1, 1);
    frame("t3_floor", 198, 424, 1, 1);
    frame("t3_up1", 197, 420, 1, 1);
    frame("t3_up2", 196, 416, 1, 1);
    // hit, freeze and split at level 2
    do_reset;
    do_launch(300, 100, 1, 2);
    do_hit("t4_hit", 1'b0, 300, 100, 2);
    snap("t4_frozen", 300, 100, 2, 1);
    expect_pulse("t4_split", 1'b1, 2);
    for (int i = 0; i < 8; i++) frame("t4_freeze", 300, 100, 2, 1);
    cyc(2);
    snap("t4_after", 300, 100, 2, 0);
    // hit with frame pulse wins; launch during freeze ignored; pop at level 0
    do_reset;
    do_launch(50, 60, 0, 0);
    do_hit("t5_hit_sof", 1'b1, 50, 60, 0);
    do_launch(500, 500, 1, 3);
    snap("t5_no_launch", 50, 60, 0, 1);
    expect_pulse("t5_pop", 1'b0, 0);
    for (int i = 0; i < 8; i++) frame("t5_freeze", 50, 60, 0, 1);
    cyc(2);
    snap("t5_after", 50, 60, 0, 0);
    // pause holds position and freeze counter
    do_reset;
    do_launch(100, 100, 1, 1);
    frame("t6_f1", 101, 100, 1, 1);
    frame("t6_paused", 101, 100, 1, 1, 1'b1);
    do_hit("t6_hit", 1'b0, 101, 100, 1);
    for (int i = 0; i < 7; i++) frame("t6_freeze", 101, 100, 1, 1);
    for (int i = 0; i < 3; i++) frame("t6_freeze_paused", 101, 100, 1, 1, 1'b1);
    expect_pulse("t6_split", 1'b1, 1);
    frame("t6_last", 101, 100, 1, 1);
    cyc(2);
    // launch+hit in IDLE takes launch, then reset mid-freeze
    do_launch(200, 200, 1, 1, 1'b1);
    frame("t8_moving", 201, 200, 1, 1);
    do_hit("t8_hit", 1'b0, 201, 200, 1);
    for (int i = 0; i < 3; i++) frame("t8_freeze", 201, 200, 1, 1);
    do_reset;
    snap("t8_reset", 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) frame("t8_idle", 0, 0, 0, 0);
    cyc(4);
    checks++;
    if (pq.size() != 0) begin
      failures++;
      $display("FAIL missing_pulse got=%0d_pending expected=0", pq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
